// File: rtl/mem_bus_arbiter.sv
// Registered five-state arbiter sharing one memory port between ibus and dbus.
// Optional macro MEM_ARB_RR_EN selects round-robin priority on contention.
package mem_bus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  mreq,
    input  dbus_resp_t mresp,
    output logic       busy,
    output logic [1:0] owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_ADDR,
        S_I_DATA,
        S_D_ADDR,
        S_D_DATA
    } state_t;

    state_t     state_q;
    logic [1:0] owner_q;
    logic       busy_q;
    logic       dbus_first;
    logic       addr_ph;
    logic       data_ph;
    dbus_resp_t rsp;

`ifdef MEM_ARB_RR_EN
    // 0 = ibus granted last, 1 = dbus granted last
    logic last_grant_q;

    assign dbus_first = dreq.valid
                      & (~ireq.valid | ~last_grant_q);
`else
    assign dbus_first = dreq.valid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 2'b00;
            busy_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dbus_first) begin
                        state_q <= S_D_ADDR;
                        owner_q <= 2'b10;
                        busy_q  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= 1'b1;
`endif
                    end else if (ireq.valid) begin
                        state_q <= S_I_ADDR;
                        owner_q <= 2'b01;
                        busy_q  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= 1'b0;
`endif
                    end
                end
                S_I_ADDR, S_D_ADDR: begin
                    if (mresp.addr_ok) begin
                        if (mresp.data_ok) begin
                            state_q <= S_IDLE;
                            owner_q <= 2'b00;
                            busy_q  <= 1'b0;
                        end else if (state_q == S_I_ADDR) begin
                            state_q <= S_I_DATA;
                        end else begin
                            state_q <= S_D_DATA;
                        end
                    end
                end
                S_I_DATA, S_D_DATA: begin
                    if (mresp.data_ok) begin
                        state_q <= S_IDLE;
                        owner_q <= 2'b00;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    owner_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_ph = (state_q == S_I_ADDR)
                   | (state_q == S_D_ADDR);
    assign data_ph = (state_q == S_I_DATA)
                   | (state_q == S_D_DATA);

    // data_ok in the address phase only counts alongside addr_ok
    always_comb begin
        rsp = '0;
        if (addr_ph) begin
            rsp.addr_ok = mresp.addr_ok;
            rsp.data_ok = mresp.addr_ok & mresp.data_ok;
        end else if (data_ph) begin
            rsp.data_ok = mresp.data_ok;
        end
        rsp.data = rsp.data_ok ? mresp.data : 32'h0;
    end

    always_comb begin
        mreq  = '0;
        iresp = '0;
        dresp = '0;
        if (!reset) begin
            case (state_q)
                S_I_ADDR: begin
                    mreq.valid = ireq.valid;
                    mreq.addr  = ireq.addr;
                    mreq.size  = MSIZE4;
                    iresp      = ibus_resp_t'(rsp);
                end
                S_I_DATA: iresp = ibus_resp_t'(rsp);
                S_D_ADDR: begin
                    mreq  = dreq;
                    dresp = rsp;
                end
                S_D_DATA: dresp = rsp;
                default: ;
            endcase
        end
    end

    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  mreq;
    dbus_resp_t mresp;
    logic       busy;
    logic [1:0] owner;

    mem_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model: who holds the port and whether its address was accepted
    int   m_own = 0;
    bit   m_acc = 0;
    bit   m_last = 0;

    dbus_req_t  e_mreq;
    ibus_resp_t e_ir;
    dbus_resp_t e_dr;

    dbus_req_t  o_mreq;
    ibus_resp_t o_ir;
    dbus_resp_t o_dr;
    logic [1:0] o_owner;
    logic       o_busy;

    task automatic chk(input string tag,
                       input logic [79:0] got,
                       input logic [79:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic ibus_req_t ir_f(logic v, logic [31:0] a);
        ibus_req_t r;
        r.valid = v;
        r.addr  = a;
        return r;
    endfunction

    function automatic dbus_req_t dr_f(logic v, logic [31:0] a,
                                       msize_t sz, logic [3:0] st,
                                       logic [31:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = sz;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    function automatic dbus_resp_t mr_f(logic a, logic d,
                                        logic [31:0] x);
        dbus_resp_t r;
        r.addr_ok = a;
        r.data_ok = d;
        r.data    = x;
        return r;
    endfunction

    task automatic cyc(input ibus_req_t ir, input dbus_req_t dr,
                       input dbus_resp_t mr, input logic rst);
        dbus_resp_t rs;
        bit         d_wins;
        int         n_own;
        bit         n_acc;
        bit         n_last;
        @(negedge clk);
        ireq  = ir;
        dreq  = dr;
        mresp = mr;
        reset = rst;
        #1;
        o_mreq  = mreq;
        o_ir    = iresp;
        o_dr    = dresp;
        o_owner = owner;
        o_busy  = busy;
        e_mreq = '0;
        e_ir   = '0;
        e_dr   = '0;
        rs     = '0;
        if (m_own != 0) begin
            if (!m_acc) begin
                rs.addr_ok = mr.addr_ok;
                rs.data_ok = mr.addr_ok && mr.data_ok;
            end else begin
                rs.data_ok = mr.data_ok;
            end
            rs.data = rs.data_ok ? mr.data : 32'h0;
        end
        if (!rst) begin
            if (m_own == 1) begin
                e_ir = ibus_resp_t'(rs);
                if (!m_acc) begin
                    e_mreq.valid = ir.valid;
                    e_mreq.addr  = ir.addr;
                    e_mreq.size  = MSIZE4;
                end
            end else if (m_own == 2) begin
                e_dr = rs;
                if (!m_acc) e_mreq = dr;
            end
        end
        chk("mreq", {8'b0, o_mreq}, {8'b0, e_mreq});
        chk("iresp", {46'b0, o_ir}, {46'b0, e_ir});
        chk("dresp", {46'b0, o_dr}, {46'b0, e_dr});
        chk("owner", {78'b0, o_owner}, 80'(m_own));
        chk("busy", {79'b0, o_busy}, {79'b0, m_own != 0});
        n_own  = m_own;
        n_acc  = m_acc;
        n_last = m_last;
        if (rst) begin
            n_own  = 0;
            n_acc  = 0;
            n_last = 0;
        end else if (m_own == 0) begin
`ifdef MEM_ARB_RR_EN
            d_wins = dr.valid && (!ir.valid || !m_last);
`else
            d_wins = dr.valid;
`endif
            n_acc = 0;
            if (d_wins) begin
                n_own  = 2;
                n_last = 1;
            end else if (ir.valid) begin
                n_own  = 1;
                n_last = 0;
            end
        end else if (rs.data_ok) begin
            n_own = 0;
            n_acc = 0;
        end else if (rs.addr_ok) begin
            n_acc = 1;
        end
        @(posedge clk);
        m_own  = n_own;
        m_acc  = n_acc;
        m_last = n_last;
    endtask

    ibus_req_t  i0, ia, ib;
    dbus_req_t  d0, da;
    dbus_resp_t m0;
    bit         i_pend, d_pend;

    initial begin
        i0 = '0;
        d0 = '0;
        m0 = '0;
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        cyc(i0, d0, m0, 1'b1);

        // single fetch
        ia = ir_f(1'b1, 32'hBFC00000);
        cyc(ia, d0, m0, 1'b0);
        cyc(ia, d0, mr_f(1'b1, 1'b0, 32'h0), 1'b0);
        chk("fetch_own", {78'b0, o_owner}, 80'd1);
        chk("fetch_addr", {48'b0, o_mreq.addr}, 80'hBFC00000);
        cyc(i0, d0, m0, 1'b0);
        cyc(i0, d0, mr_f(1'b0, 1'b1, 32'h24080001), 1'b0);
        chk("fetch_dok", {79'b0, o_ir.data_ok}, 80'd1);
        chk("fetch_data", {48'b0, o_ir.data}, 80'h24080001);
        cyc(i0, d0, m0, 1'b0);

        // simultaneous requests from reset
        cyc(i0, d0, m0, 1'b1);
        ia = ir_f(1'b1, 32'h1000);
        da = dr_f(1'b1, 32'h2000, MSIZE4, 4'h0, 32'h0);
        cyc(ia, da, m0, 1'b0);
        cyc(ia, da, mr_f(1'b1, 1'b0, 32'h0), 1'b0);
        chk("sim_first", {48'b0, o_mreq.addr}, 80'h2000);
        cyc(ia, d0, mr_f(1'b0, 1'b1, 32'h55), 1'b0);
        cyc(ia, d0, m0, 1'b0);
        chk("sim_gap", {79'b0, o_mreq.valid}, 80'd0);
        cyc(ia, d0, mr_f(1'b1, 1'b1, 32'h77), 1'b0);
        chk("sim_second", {48'b0, o_mreq.addr}, 80'h1000);
        cyc(i0, d0, m0, 1'b0);

        // fast path store
        da = dr_f(1'b1, 32'h80000010, MSIZE4, 4'hF, 32'hDEADBEEF);
        cyc(i0, da, m0, 1'b0);
        cyc(i0, da, mr_f(1'b1, 1'b1, 32'h0), 1'b0);
        chk("fast_both", {78'b0, o_dr.addr_ok, o_dr.data_ok}, 80'd3);
        chk("fast_wdata", {48'b0, o_mreq.data}, 80'hDEADBEEF);
        cyc(i0, d0, m0, 1'b0);
        chk("fast_idle", {78'b0, o_owner}, 80'd0);

        // stray responses in IDLE
        repeat (3) cyc(i0, d0, mr_f(1'b1, 1'b1, 32'h1234), 1'b0);
        chk("stray_busy", {79'b0, o_busy}, 80'd0);

        // non-owner ibus waits while dbus sits in D_DATA
        ib = ir_f(1'b1, 32'h3000);
        da = dr_f(1'b1, 32'h4000, MSIZE2, 4'h3, 32'hAB);
        cyc(ib, da, m0, 1'b0);
        cyc(ib, da, mr_f(1'b1, 1'b0, 32'h0), 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(ib, d0, mr_f(1'b1, 1'b0, 32'h0), 1'b0);
            chk("nonown_aok", {79'b0, o_ir.addr_ok}, 80'd0);
        end
        cyc(ib, d0, mr_f(1'b0, 1'b1, 32'h9), 1'b0);
        cyc(ib, d0, m0, 1'b0);
        cyc(ib, d0, mr_f(1'b1, 1'b1, 32'hA), 1'b0);
        chk("nonown_grant", {79'b0, o_ir.addr_ok}, 80'd1);

        // reset in D_DATA
        da = dr_f(1'b1, 32'h5000, MSIZE4, 4'h0, 32'h0);
        cyc(i0, da, m0, 1'b0);
        cyc(i0, da, mr_f(1'b1, 1'b0, 32'h0), 1'b0);
        cyc(i0, d0, m0, 1'b0);
        cyc(i0, d0, mr_f(1'b0, 1'b1, 32'hC0DE), 1'b1);
        chk("rst_dresp", {46'b0, o_dr}, 80'd0);
        cyc(i0, d0, m0, 1'b1);
        cyc(i0, d0, mr_f(1'b0, 1'b1, 32'hC0DE), 1'b0);
        chk("rst_late", {79'b0, o_dr.data_ok}, 80'd0);
        chk("rst_own", {78'b0, o_owner}, 80'd0);

`ifdef MEM_ARB_RR_EN
        cyc(i0, d0, m0, 1'b1);
        ia = ir_f(1'b1, 32'h6000);
        da = dr_f(1'b1, 32'h7000, MSIZE4, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(ia, da, m0, 1'b0);
            cyc(ia, da, mr_f(1'b1, 1'b1, 32'h1), 1'b0);
            chk("rr_own", {78'b0, o_owner},
                (k % 2 == 0) ? 80'd2 : 80'd1);
        end
        cyc(i0, d0, m0, 1'b0);
`endif

        // random traffic
        i_pend = 0;
        d_pend = 0;
        ia = i0;
        da = d0;
        for (int n = 0; n < 600; n++) begin
            bit rst;
            rst = ($urandom_range(0, 99) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                ia = ir_f(1'b1, $urandom);
                i_pend = 1;
            end else if (!i_pend) begin
                ia = i0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                da = dr_f(1'b1, $urandom,
                          msize_t'($urandom_range(0, 2)),
                          4'($urandom), $urandom);
                d_pend = 1;
            end else if (!d_pend) begin
                da = d0;
            end
            cyc(ia, da,
                mr_f(1'($urandom), $urandom_range(0, 2) == 0,
                     $urandom),
                rst);
            if (e_ir.addr_ok || rst) i_pend = 0;
            if (e_dr.addr_ok || rst) d_pend = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
